tft_pixel_fifo: RTL and testbench



---
 rtl/tft_pixel_fifo_if.sv | 11 +
 rtl/tft_pixel_fifo.sv | 173 +++++++++++++++++
 tb/tb_tft_pixel_fifo.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/tft_pixel_fifo_if.sv
// Pixel stream between the capture FIFO and the TFT writer.
// master: FIFO side (drives valid/data/sof). slave: writer side (drives ready).
interface tft_pixel_fifo_if;
  logic        pix_valid;
  logic        pix_ready;
  logic [15:0] pix_data;
  logic        pix_sof;

  modport master (output pix_valid, output pix_data, output pix_sof, input pix_ready);
  modport slave  (input pix_valid, input pix_data, input pix_sof, output pix_ready);
endinterface

// File: rtl/tft_pixel_fifo.sv
// tft_pixel_fifo: captures one 3:3:3 sample per new visible hc/vc coordinate,
// expands it to RGB565 and buffers it in a show-ahead FIFO with an SOF marker.
// After a dropped pixel, capture is suspended until the next (0,0) so the
// consumer never sees a partial frame.
// Optional feature macro: TFT_PIXEL_FIFO_OVF_COUNT_EN (saturating drop counter).
module tft_pixel_fifo #(
  parameter int H_ACTIVE = 320,
  parameter int V_ACTIVE = 240,
  parameter int DEPTH    = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [2:0]               r,
  input  logic [2:0]               g,
  input  logic [2:0]               b,
  input  logic [8:0]               hc,
  input  logic [8:0]               vc,
  tft_pixel_fifo_if.master         pix,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow,
  input  logic                     ovf_clr,
  output logic [15:0]              ovf_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [8:0]  H_LIM    = 9'(H_ACTIVE);
  localparam logic [8:0]  V_LIM    = 9'(V_ACTIVE);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {SYNC, RUN, RESYNC} state_t;

  // Input stage and candidate stage registers
  logic [2:0]  s1_r_q, s1_g_q, s1_b_q;
  logic [8:0]  s1_hc_q, s1_vc_q, s2_hc_q;
  logic        cand_vld_q, cand_sof_q;
  logic [15:0] cand_data_q;

  logic        new_pix, visible, sof_pix;
  logic [15:0] colour;

  assign new_pix = (s1_hc_q != s2_hc_q);
  assign visible = (s1_hc_q < H_LIM) && (s1_vc_q < V_LIM);
  assign sof_pix = (s1_hc_q == 9'd0) && (s1_vc_q == 9'd0);
  assign colour  = {s1_r_q, s1_r_q[2:1], s1_g_q, s1_g_q, s1_b_q, s1_b_q[2:1]};

  // Register raw inputs (s1), previous hc (s2) and the visible-pixel candidate
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_r_q      <= '0;
      s1_g_q      <= '0;
      s1_b_q      <= '0;
      s1_hc_q     <= '0;
      s1_vc_q     <= '0;
      s2_hc_q     <= '0;
      cand_vld_q  <= 1'b0;
      cand_sof_q  <= 1'b0;
      cand_data_q <= '0;
    end else begin
      s1_r_q      <= r;
      s1_g_q      <= g;
      s1_b_q      <= b;
      s1_hc_q     <= hc;
      s1_vc_q     <= vc;
      s2_hc_q     <= s1_hc_q;
      cand_vld_q  <= new_pix && visible;
      cand_sof_q  <= sof_pix;
      cand_data_q <= colour;
    end
  end

  // FIFO state
  logic [16:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  state_t        state_q, state_d;
  logic          push, drop, pop, room;
  logic [16:0]   head;

  assign pop  = pix.pix_valid && pix.pix_ready;
  assign room = (level_q != FULL_LVL) || pop;

  // Capture FSM: decides push/drop for the registered candidate
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    drop    = 1'b0;
    unique case (state_q)
      SYNC, RESYNC: begin
        if (cand_vld_q && cand_sof_q) begin
          if (room) begin
            push    = 1'b1;
            state_d = RUN;
          end else begin
            drop    = 1'b1;
            state_d = RESYNC;
          end
        end
      end
      RUN: begin
        if (cand_vld_q) begin
          if (room) begin
            push = 1'b1;
          end else begin
            drop    = 1'b1;
            state_d = RESYNC;
          end
        end
      end
      default: state_d = SYNC;
    endcase
  end

  // Pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    level_d  = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // FSM, pointers, occupancy and sticky overflow flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= SYNC;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      overflow <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  // Pixel storage: {sof, rgb565}
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cand_sof_q, cand_data_q};
  end

  assign head          = mem_q[rd_ptr_q];
  assign fifo_level    = level_q;
  assign pix.pix_valid = (level_q != '0);
  assign pix.pix_data  = pix.pix_valid ? head[15:0] : 16'h0000;
  assign pix.pix_sof   = pix.pix_valid && head[16];

`ifdef TFT_PIXEL_FIFO_OVF_COUNT_EN
  logic [15:0] ovf_cnt_q;

  // Saturating dropped-pixel counter; an increment beats a clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_cnt_q <= '0;
    end else if (drop) begin
      if (ovf_cnt_q != 16'hFFFF) ovf_cnt_q <= ovf_cnt_q + 16'd1;
    end else if (ovf_clr) begin
      ovf_cnt_q <= '0;
    end
  end

  assign ovf_count = ovf_cnt_q;
`else
  assign ovf_count = 16'h0000;
`endif

endmodule

// File: tb/tb_tft_pixel_fifo.sv
// Directed bench for tft_pixel_fifo: a scoreboard queue receives the expected
// {sof, rgb565} for every pixel that should be stored and is checked against
// each accepted output beat.
module tb_tft_pixel_fifo;

`ifdef TFT_PIXEL_FIFO_OVF_COUNT_EN
  localparam int EXP_CNT1 = 1;
`else
  localparam int EXP_CNT1 = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  r, g, b;
  logic [8:0]  hc, vc;
  logic [4:0]  fifo_level;
  logic        overflow;
  logic        ovf_clr;
  logic [15:0] ovf_count;

  tft_pixel_fifo_if pif ();

  tft_pixel_fifo #(.H_ACTIVE(320), .V_ACTIVE(240), .DEPTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .r          (r),
    .g          (g),
    .b          (b),
    .hc         (hc),
    .vc         (vc),
    .pix        (pif),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr),
    .ovf_count  (ovf_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [16:0] expq[$];

  logic       cur_rst = 1'b0;
  logic [2:0] cur_r = '0, cur_g = '0, cur_b = '0;
  logic [8:0] cur_hc = '0, cur_vc = '0;
  logic       cur_ready = 1'b0;
  logic       cur_clr = 1'b0;

  function automatic logic [15:0] conv(input logic [2:0] rr, input logic [2:0] gg, input logic [2:0] bb);
    return {rr, rr[2:1], gg, gg, bb, bb[2:1]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: inputs applied just after the rising edge, output beat
  // checked on the falling edge (it is accepted at the next rising edge).
  task automatic tick();
    logic [16:0] e;
    @(posedge clk);
    #1;
    rst_n         = cur_rst;
    r             = cur_r;
    g             = cur_g;
    b             = cur_b;
    hc            = cur_hc;
    vc            = cur_vc;
    pif.pix_ready = cur_ready;
    ovf_clr       = cur_clr;
    @(negedge clk);
    if (rst_n && pif.pix_valid && pif.pix_ready) begin
      if (expq.size() == 0) begin
        chk("unexpected_pop", 32'(pif.pix_data), 32'hDEAD_BEEF);
      end else begin
        e = expq.pop_front();
        $display("pop data=%04h sof=%0b exp=%04h/%0b", pif.pix_data, pif.pix_sof, e[15:0], e[16]);
        chk("pop_data", 32'(pif.pix_data), 32'(e[15:0]));
        chk("pop_sof", 32'(pif.pix_sof), 32'(e[16]));
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic px(input int h, input int v, input int rr, input int gg, input int bb, input bit exp);
    cur_hc = 9'(h);
    cur_vc = 9'(v);
    cur_r  = 3'(rr);
    cur_g  = 3'(gg);
    cur_b  = 3'(bb);
    if (exp) expq.push_back({(h == 0 && v == 0), conv(cur_r, cur_g, cur_b)});
    tick();
  endtask

  task automatic wait_empty(input string tag);
    int n = 0;
    while ((fifo_level != 5'd0 || expq.size() != 0) && n < 64) begin
      tick();
      n++;
    end
    chk(tag, 32'(fifo_level == 5'd0 && expq.size() == 0), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; r = '0; g = '0; b = '0; hc = '0; vc = '0;
    pif.pix_ready = 1'b0; ovf_clr = 1'b0;

    // Reset state
    idle(3);
    cur_rst = 1'b1;
    tick();
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_valid", 32'(pif.pix_valid), 32'd0);
    chk("rst_data", 32'(pif.pix_data), 32'd0);
    chk("rst_sof", 32'(pif.pix_sof), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_cnt", 32'(ovf_count), 32'd0);

    // Sync: mid-frame start is ignored until (0,0)
    cur_ready = 1'b1;
    for (int h = 0; h < 20; h++) px(h, 100, 5, 5, 5, 1'b0);
    idle(4);
    chk("sync_level", 32'(fifo_level), 32'd0);
    chk("sync_valid", 32'(pif.pix_valid), 32'd0);
    for (int h = 0; h < 320; h++) px(h, 0, $urandom_range(7, 0), $urandom_range(7, 0), $urandom_range(7, 0), 1'b1);
    for (int h = 320; h < 448; h++) px(h, 0, 7, 7, 7, 1'b0);
    chk("hblank_level", 32'(fifo_level), 32'd0);
    chk("hblank_q", 32'(expq.size()), 32'd0);
    for (int h = 0; h < 320; h++) px(h, 1, $urandom_range(7, 0), $urandom_range(7, 0), $urandom_range(7, 0), 1'b1);
    wait_empty("line1_drain");
    for (int v = 240; v < 312; v += 12)
      for (int h = 0; h < 10; h++) px(h, v, 7, 7, 7, 1'b0);
    chk("vblank_level", 32'(fifo_level), 32'd0);

    // Colour expansion constants
    for (int h = 0; h < 4; h++) begin
      expq.push_back({1'b0, 16'hF80D});
      px(h, 2, 7, 0, 3, 1'b0);
    end
    for (int h = 4; h < 8; h++) begin
      expq.push_back({1'b0, 16'h9244});
      px(h, 2, 4, 2, 1, 1'b0);
    end
    expq.push_back({1'b0, 16'hFFFF});
    px(8, 2, 7, 7, 7, 1'b0);
    expq.push_back({1'b0, 16'h9000});
    px(9, 2, 4, 0, 0, 1'b0);
    wait_empty("colour_drain");

    // Overflow: fill 16, drop the 17th, then resync at next (0,0)
    cur_ready = 1'b0;
    for (int h = 0; h < 16; h++) px(h, 0, h % 8, 3, 1, 1'b1);
    idle(4);
    chk("full_level", 32'(fifo_level), 32'd16);
    chk("full_ovf", 32'(overflow), 32'd0);
    px(16, 0, 1, 1, 1, 1'b0);
    idle(4);
    chk("drop_ovf", 32'(overflow), 32'd1);
    chk("drop_cnt", 32'(ovf_count), 32'(EXP_CNT1));
    chk("drop_level", 32'(fifo_level), 32'd16);
    for (int h = 17; h < 31; h++) px(h, 0, 2, 2, 2, 1'b0);
    cur_ready = 1'b1;
    for (int h = 31; h < 61; h++) px(h, 0, 2, 2, 2, 1'b0);
    wait_empty("resync_drain");
    idle(5);
    chk("resync_idle", 32'(fifo_level), 32'd0);
    for (int h = 0; h < 4; h++) px(h, 0, 6, 5, 4, 1'b1);
    wait_empty("resync_frame");
    cur_clr = 1'b1;
    tick();
    cur_clr = 1'b0;
    tick();
    chk("clr_ovf", 32'(overflow), 32'd0);
    chk("clr_cnt", 32'(ovf_count), 32'd0);

    // Full plus simultaneous pop: push accepted, level unchanged, no drop
    cur_ready = 1'b0;
    for (int h = 0; h < 16; h++) px(h, 0, 3, h % 8, 5, 1'b1);
    idle(4);
    chk("fp_level0", 32'(fifo_level), 32'd16);
    px(16, 0, 1, 2, 3, 1'b1);
    tick();
    cur_ready = 1'b1;
    tick();
    chk("fp_level1", 32'(fifo_level), 32'd16);
    cur_ready = 1'b0;
    tick();
    chk("fp_level2", 32'(fifo_level), 32'd16);
    chk("fp_ovf", 32'(overflow), 32'd0);
    idle(3);
    chk("fp_cnt", 32'(ovf_count), 32'd0);
    cur_ready = 1'b1;
    wait_empty("fp_drain");

    // Reset mid-frame with 9 stored pixels
    cur_ready = 1'b0;
    for (int h = 0; h < 9; h++) px(h, 0, 1, 6, 2, 1'b1);
    idle(4);
    chk("mr_level9", 32'(fifo_level), 32'd9);
    cur_rst = 1'b0;
    tick();
    cur_rst = 1'b1;
    expq.delete();
    tick();
    chk("mr_valid", 32'(pif.pix_valid), 32'd0);
    chk("mr_level", 32'(fifo_level), 32'd0);
    chk("mr_ovf", 32'(overflow), 32'd0);
    cur_ready = 1'b1;
    for (int h = 9; h < 31; h++) px(h, 0, 1, 1, 1, 1'b0);
    idle(4);
    chk("mr_nocap", 32'(fifo_level), 32'd0);
    cur_ready = 1'b0;
    px(0, 0, 7, 0, 3, 1'b1);
    tick();
    chk("lat_c1", 32'(pif.pix_valid), 32'd0);
    tick();
    chk("lat_c2", 32'(pif.pix_valid), 32'd0);
    tick();
    chk("lat_c3", 32'(pif.pix_valid), 32'd1);
    chk("lat_sof", 32'(pif.pix_sof), 32'd1);
    chk("lat_data", 32'(pif.pix_data), 32'h0000F80D);
    cur_ready = 1'b1;
    for (int h = 1; h < 4; h++) px(h, 0, 4, 2, 1, 1'b1);
    wait_empty("final_drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
